// File: rtl/bch_serial_codeword_assembler.sv
`default_nettype none
// ============================================================================
// Module   : bch_serial_codeword_assembler
// Brief    : Assembles MSB-first serial channel bits into CODE_WIDTH-bit
//            codewords and presents them on a valid/ready interface to the
//            parallel BCH decoder. Shift register plus output register give
//            gap-free back-to-back framing. Flags framing and overflow faults.
// Revision : 1.0 - initial release
// ============================================================================
module bch_serial_codeword_assembler #(
  parameter int CODE_WIDTH = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  bit_in,
  input  logic                  bit_valid,
  input  logic                  frame_start,
  output logic [CODE_WIDTH-1:0] cw_data,
  output logic                  cw_valid,
  input  logic                  cw_ready,
  output logic                  framing_error,
  output logic                  overflow,
  input  logic                  clear_flags,
  output logic [CNT_WIDTH-1:0]  cw_count
);

  localparam int                  c_BCNT_W   = $clog2(CODE_WIDTH);
  localparam logic [c_BCNT_W-1:0] c_LAST_IDX = c_BCNT_W'(CODE_WIDTH - 1);
  localparam logic [c_BCNT_W-1:0] c_ONE      = c_BCNT_W'(1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // The shift register holds only the bits received so far; the final bit
  // of a codeword is taken straight from bit_in, so CODE_WIDTH-1 bits suffice.
  state_t                r_state,         w_state;
  logic [c_BCNT_W-1:0]   r_bit_cnt,       w_bit_cnt;
  logic [CODE_WIDTH-2:0] r_shreg,         w_shreg;
  logic [CODE_WIDTH-1:0] r_cw_data,       w_cw_data;
  logic                  r_cw_valid,      w_cw_valid;
  logic                  r_framing_error, w_framing_error;
  logic                  r_overflow,      w_overflow;
  logic [CNT_WIDTH-1:0]  r_cw_count,      w_cw_count;
  logic                  w_complete;
  logic                  w_handshake;
  logic [CODE_WIDTH-1:0] w_word;

  // Next-state, assembly and output-register decisions.
  always_comb begin
    w_state         = r_state;
    w_bit_cnt       = r_bit_cnt;
    w_shreg         = r_shreg;
    w_cw_data       = r_cw_data;
    w_cw_valid      = r_cw_valid;
    w_framing_error = 1'b0;
    w_overflow      = r_overflow;
    w_cw_count      = r_cw_count;
    w_complete      = 1'b0;
    w_handshake     = r_cw_valid && cw_ready;
    w_word          = {r_shreg, bit_in};

    case (r_state)
      ST_IDLE: begin
        // Bits outside a frame are discarded until a frame_start arrives.
        if (bit_valid && frame_start) begin
          w_shreg   = {{(CODE_WIDTH-2){1'b0}}, bit_in};
          w_bit_cnt = c_ONE;
          w_state   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (bit_valid) begin
          if (frame_start) begin
            // Restart: the partial word is dropped and this bit becomes MSB.
            w_framing_error = 1'b1;
            w_shreg         = {{(CODE_WIDTH-2){1'b0}}, bit_in};
            w_bit_cnt       = c_ONE;
          end else if (r_bit_cnt == c_LAST_IDX) begin
            w_complete = 1'b1;
            w_bit_cnt  = '0;
            w_state    = ST_IDLE;
          end else begin
            w_shreg   = {r_shreg[CODE_WIDTH-3:0], bit_in};
            w_bit_cnt = r_bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        w_state   = ST_IDLE;
        w_bit_cnt = '0;
      end
    endcase

    if (clear_flags) begin
      w_overflow = 1'b0;
    end

    if (w_handshake) begin
      w_cw_valid = 1'b0;
      w_cw_count = r_cw_count + 1'b1;
    end

    // A completion in the handshake cycle reloads the register seamlessly;
    // with the register still owned by the decoder the new word is lost.
    if (w_complete) begin
      if (!r_cw_valid || cw_ready) begin
        w_cw_data  = w_word;
        w_cw_valid = 1'b1;
      end else begin
        w_overflow = 1'b1;
      end
    end
  end

  // State and datapath registers; reset discards any partial or pending word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_bit_cnt       <= '0;
      r_shreg         <= '0;
      r_cw_data       <= '0;
      r_cw_valid      <= 1'b0;
      r_framing_error <= 1'b0;
      r_overflow      <= 1'b0;
      r_cw_count      <= '0;
    end else begin
      r_state         <= w_state;
      r_bit_cnt       <= w_bit_cnt;
      r_shreg         <= w_shreg;
      r_cw_data       <= w_cw_data;
      r_cw_valid      <= w_cw_valid;
      r_framing_error <= w_framing_error;
      r_overflow      <= w_overflow;
      r_cw_count      <= w_cw_count;
    end
  end

  assign cw_data       = r_cw_data;
  assign cw_valid      = r_cw_valid;
  assign framing_error = r_framing_error;
  assign overflow      = r_overflow;
  assign cw_count      = r_cw_count;

endmodule
`default_nettype wire

// File: tb/tb_bch_serial_codeword_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_bch_serial_codeword_assembler
// Brief    : Directed plus randomized bench for the serial codeword
//            assembler, checked against a frame-level queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bch_serial_codeword_assembler;

  localparam int CW    = 15;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             bit_in;
  logic             bit_valid;
  logic             frame_start;
  logic [CW-1:0]    cw_data;
  logic             cw_valid;
  logic             cw_ready;
  logic             framing_error;
  logic             overflow;
  logic             clear_flags;
  logic [CNT_W-1:0] cw_count;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: bits of the open frame kept in a queue, one output slot.
  bit            m_q[$];
  bit            m_in_frame;
  logic          m_valid;
  logic [CW-1:0] m_data;
  int            m_count;
  logic          m_ovf;
  logic          m_fe;

  always #5 clk = ~clk;

  bch_serial_codeword_assembler #(
    .CODE_WIDTH (CW),
    .CNT_WIDTH  (CNT_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bit_in        (bit_in),
    .bit_valid     (bit_valid),
    .frame_start   (frame_start),
    .cw_data       (cw_data),
    .cw_valid      (cw_valid),
    .cw_ready      (cw_ready),
    .framing_error (framing_error),
    .overflow      (overflow),
    .clear_flags   (clear_flags),
    .cw_count      (cw_count)
  );

  function automatic void model_reset();
    m_q.delete();
    m_in_frame = 1'b0;
    m_valid    = 1'b0;
    m_data     = '0;
    m_count    = 0;
    m_ovf      = 1'b0;
    m_fe       = 1'b0;
  endfunction

  // Applies one clock edge worth of spec rules to the model.
  function automatic void model_edge();
    logic          was_valid;
    logic          hs;
    logic          done;
    logic [CW-1:0] word;
    was_valid = m_valid;
    hs        = m_valid && cw_ready;
    done      = 1'b0;
    word      = '0;
    m_fe      = 1'b0;
    if (bit_valid) begin
      if (frame_start) begin
        m_fe = m_in_frame;
        m_q.delete();
        m_q.push_back(bit_in);
        m_in_frame = 1'b1;
      end else if (m_in_frame) begin
        m_q.push_back(bit_in);
        if (m_q.size() == CW) begin
          foreach (m_q[i]) word = {word[CW-2:0], m_q[i]};
          done = 1'b1;
          m_q.delete();
          m_in_frame = 1'b0;
        end
      end
    end
    if (clear_flags) m_ovf = 1'b0;
    if (hs) begin
      m_count = (m_count + 1) % (1 << CNT_W);
      m_valid = 1'b0;
    end
    if (done) begin
      if (!was_valid || cw_ready) begin
        m_data  = word;
        m_valid = 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("cw_valid",      64'(cw_valid),      64'(m_valid));
    chk("cw_data",       64'(cw_data),       64'(m_data));
    chk("overflow",      64'(overflow),      64'(m_ovf));
    chk("framing_error", 64'(framing_error), 64'(m_fe));
    chk("cw_count",      64'(cw_count),      64'(m_count));
  endtask

  task automatic cycle(input logic bv, input logic fs, input logic b,
                       input logic rdy, input logic clr);
    bit_valid   = bv;
    frame_start = fs;
    bit_in      = b;
    cw_ready    = rdy;
    clear_flags = clr;
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  function automatic logic pick_rdy(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return 1'($urandom_range(0, 1));
  endfunction

  // mode/last_mode: 0 = ready low, 1 = ready high, 2 = random per cycle.
  task automatic send_frame(input logic [CW-1:0] w, input int gap_pct,
                            input int mode, input int last_mode);
    for (int i = 0; i < CW; i++) begin
      while (gap_pct > 0 && $urandom_range(0, 99) < gap_pct)
        cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_rdy(mode), 1'b0);
      cycle(1'b1, (i == 0), w[CW-1-i], (i == CW-1) ? pick_rdy(last_mode) : pick_rdy(mode), 1'b0);
    end
  endtask

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, pick_rdy(mode), 1'b0);
  endtask

  initial begin
    logic [CW-1:0] w;
    rst_n       = 1'b0;
    bit_in      = 1'b0;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    cw_ready    = 1'b0;
    clear_flags = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
    idle(1, 0);

    // Single frame, continuous bits, decoder ready.
    send_frame(15'h5A3C, 0, 1, 1);
    chk("t1_valid", 64'(cw_valid), 64'd1);
    chk("t1_data",  64'(cw_data),  64'h5A3C);
    idle(1, 1);
    chk("t1_count", 64'(cw_count), 64'd1);

    // Back-to-back with decoder stalled: second word dropped.
    send_frame(15'h7FFF, 0, 0, 0);
    send_frame(15'h0001, 0, 0, 0);
    chk("t2_data", 64'(cw_data),  64'h7FFF);
    chk("t2_ovf",  64'(overflow), 64'd1);
    cycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t2_clr",  64'(overflow), 64'd0);
    idle(1, 1);
    chk("t2_count", 64'(cw_count), 64'd2);

    // Handshake coincides with completion.
    send_frame(15'h1234, 0, 0, 0);
    send_frame(15'h4321, 0, 0, 1);
    chk("t3_data",  64'(cw_data),  64'h4321);
    chk("t3_valid", 64'(cw_valid), 64'd1);
    chk("t3_count", 64'(cw_count), 64'd3);
    chk("t3_ovf",   64'(overflow), 64'd0);
    idle(1, 1);

    // Framing error: restart after 9 bits.
    cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    for (int i = 1; i < 9; i++) cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    w = 15'h2AAA;
    cycle(1'b1, 1'b1, w[CW-1], 1'b1, 1'b0);
    chk("t4_fe", 64'(framing_error), 64'd1);
    for (int i = 1; i < CW; i++) cycle(1'b1, 1'b0, w[CW-1-i], 1'b1, 1'b0);
    chk("t4_fe_off", 64'(framing_error), 64'd0);
    chk("t4_data",   64'(cw_data),       64'h2AAA);
    idle(1, 1);
    chk("t4_count",  64'(cw_count),      64'd5);

    // Stray bits in IDLE and gapped frame.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
    send_frame(15'h6B5D, 40, 1, 1);
    chk("t5_data", 64'(cw_data), 64'h6B5D);
    idle(1, 1);

    // Reset with a pending word and a partial frame.
    send_frame(15'($urandom), 0, 0, 0);
    for (int i = 0; i < 8; i++) cycle(1'b1, (i == 0), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 64'(cw_valid),      64'd0);
    chk("t6_rst_data",  64'(cw_data),       64'd0);
    chk("t6_rst_ovf",   64'(overflow),      64'd0);
    chk("t6_rst_fe",    64'(framing_error), 64'd0);
    chk("t6_rst_count", 64'(cw_count),      64'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_frame(15'h0F0F, 0, 1, 1);
    chk("t6_data", 64'(cw_data), 64'h0F0F);
    idle(1, 1);
    chk("t6_count", 64'(cw_count), 64'd1);

    // Randomized traffic: aborts, gaps, random ready and flag clears.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 4) == 0) begin
        int k;
        k = int'($urandom_range(1, CW - 1));
        for (int i = 0; i < k; i++)
          cycle(1'b1, (i == 0), 1'($urandom_range(0, 1)), pick_rdy(2), 1'b0);
      end
      send_frame(15'($urandom), 20, 2, 2);
      for (int i = 0; i < int'($urandom_range(0, 3)); i++)
        cycle(1'b0, 1'b0, 1'b0, pick_rdy(2), 1'($urandom_range(0, 3) == 0));
    end
    idle(2, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
